// File: rtl/rt_pkg.sv
// Shared constants and helpers for the real-time tick generator and the
// 256 Hz timer register block.
package rt_pkg;

  localparam logic [23:0] RT_TIMER256_CTRL = 24'h2040;
  localparam logic [23:0] RT_TIMER256_CNT  = 24'h2041;

  localparam int unsigned EN_BIT  = 32'd0;
  localparam int unsigned CLR_BIT = 32'd1;

  localparam logic [6:0] PRE_MAX = 7'd127;

  typedef struct packed {
    logic irq_1hz;
    logic irq_2hz;
    logic irq_8hz;
    logic irq_32hz;
  } irq_t;

  // Rounded phase increment: round(rt_hz * 2^acc_w / sys_hz); acc_w must stay below 64.
  function automatic longint unsigned calc_inc(input longint unsigned sys_hz,
                                               input longint unsigned rt_hz,
                                               input int unsigned     acc_w);
    longint unsigned num;
    num = rt_hz << acc_w;
    return (num + (sys_hz >> 1)) / sys_hz;
  endfunction

endpackage

// File: rtl/rt_nco.sv
// Fractional-rate clock enable: a free-running phase accumulator whose
// registered carry-out is a single-cycle enable at the average INC/2^ACC_W rate.
module rt_nco #(
  parameter int unsigned     ACC_W = 32'd32,
  parameter longint unsigned INC   = 64'd1
) (
  input  logic clk,
  input  logic reset,
  output logic rt_ce
);

  localparam logic [ACC_W-1:0] INC_W = INC[ACC_W-1:0];

  if ((INC == 64'd0) || (INC >= (64'd1 << ACC_W))) begin : g_inc_range
    $error("rt_nco: phase increment out of range for accumulator width");
  end

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W:0]   sum_s;
  logic             ce_r;

  // Accumulator add with the carry kept as the extra top bit.
  always_comb begin
    sum_s = {1'b0, acc_r} + {1'b0, INC_W};
  end

  // Phase state and registered carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= '0;
      ce_r  <= 1'b0;
    end else begin
      acc_r <= sum_s[ACC_W-1:0];
      ce_r  <= sum_s[ACC_W];
    end
  end

  assign rt_ce = ce_r;

endmodule

// File: rtl/rt_tick_gen.sv
// Real-time enable generator plus the 256 Hz timer registers (ctrl/count)
// and their periodic interrupt request pulses.
module rt_tick_gen
  import rt_pkg::*;
#(
  parameter longint unsigned SYS_CLK_HZ = 64'd40_000_000,
  parameter longint unsigned RT_HZ      = 64'd32768,
  parameter int unsigned     ACC_W      = 32'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce,
  input  logic        bus_write,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        rt_ce,
  output logic        irq_32hz,
  output logic        irq_8hz,
  output logic        irq_2hz,
  output logic        irq_1hz
);

  localparam longint unsigned INC = calc_inc(SYS_CLK_HZ, RT_HZ, ACC_W);

  logic       rt_ce_s;
  logic       enabled_r;
  logic [6:0] pre_r;
  logic [7:0] cnt_r;
  logic       tick_d_r;
  irq_t       irq_r;

  logic       ctrl_wr_s;
  logic       clr_s;
  logic       en_eff_s;
  logic       tick256_s;

  rt_nco #(
    .ACC_W (ACC_W),
    .INC   (INC)
  ) u_nco (
    .clk   (clk),
    .reset (reset),
    .rt_ce (rt_ce_s)
  );

  // A control write's enable bit governs the prescaler on the very edge it lands,
  // so disabling in the same cycle as rt_ce stops the advance.
  always_comb begin
    ctrl_wr_s = clk_ce && bus_write && (bus_address_in == RT_TIMER256_CTRL);
    if (ctrl_wr_s) begin
      en_eff_s = bus_data_in[EN_BIT];
      clr_s    = bus_data_in[CLR_BIT];
    end else begin
      en_eff_s = enabled_r;
      clr_s    = 1'b0;
    end
    tick256_s = rt_ce_s && en_eff_s && (pre_r == PRE_MAX);
  end

  // Timer state; clear beats a coincident tick and suppresses its interrupts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enabled_r <= 1'b0;
      pre_r     <= 7'd0;
      cnt_r     <= 8'd0;
      tick_d_r  <= 1'b0;
      irq_r     <= '0;
    end else begin
      if (ctrl_wr_s) begin
        enabled_r <= bus_data_in[EN_BIT];
      end
      if (clr_s) begin
        pre_r <= 7'd0;
        cnt_r <= 8'd0;
      end else if (rt_ce_s && en_eff_s) begin
        pre_r <= pre_r + 7'd1;
        if (tick256_s) begin
          cnt_r <= cnt_r + 8'd1;
        end
      end
      tick_d_r       <= tick256_s && !clr_s;
      irq_r.irq_32hz <= tick_d_r && (cnt_r[2:0] == 3'd0);
      irq_r.irq_8hz  <= tick_d_r && (cnt_r[4:0] == 5'd0);
      irq_r.irq_2hz  <= tick_d_r && (cnt_r[6:0] == 7'd0);
      irq_r.irq_1hz  <= tick_d_r && (cnt_r == 8'd0);
    end
  end

  // Register read mux.
  always_comb begin
    case (bus_address_in)
      RT_TIMER256_CTRL: bus_data_out = {7'd0, enabled_r};
      RT_TIMER256_CNT:  bus_data_out = cnt_r;
      default:          bus_data_out = 8'h00;
    endcase
  end

  assign rt_ce    = rt_ce_s;
  assign irq_32hz = irq_r.irq_32hz;
  assign irq_8hz  = irq_r.irq_8hz;
  assign irq_2hz  = irq_r.irq_2hz;
  assign irq_1hz  = irq_r.irq_1hz;

endmodule

// File: tb/tb_rt_tick_gen.sv
// Self-checking bench for rt_tick_gen: a fast-rate instance for the timer,
// plus 4-cycle and 40 MHz instances for NCO rate checks.
module tb_rt_tick_gen;

  localparam longint unsigned INC_F  = 64'd4294934528;  // 131071 Hz from 131072 Hz
  localparam longint unsigned INC_4  = 64'd1073741824;  // 32768 Hz from 131072 Hz
  localparam longint unsigned INC_40 = 64'd3518437;     // 32768 Hz from 40 MHz

  logic        clk;
  logic        reset;
  logic        clk_ce;
  logic        bus_write;
  logic [23:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata, rdata4, rdata40;
  logic        rt_ce, rt_ce4, rt_ce40;
  logic [3:0]  irq, irq4, irq40;  // {1hz, 2hz, 8hz, 32hz}

  rt_tick_gen #(.SYS_CLK_HZ(64'd131072), .RT_HZ(64'd131071), .ACC_W(32'd32)) dut (
    .clk(clk), .reset(reset), .clk_ce(clk_ce), .bus_write(bus_write),
    .bus_address_in(addr), .bus_data_in(wdata), .bus_data_out(rdata), .rt_ce(rt_ce),
    .irq_32hz(irq[0]), .irq_8hz(irq[1]), .irq_2hz(irq[2]), .irq_1hz(irq[3]));

  rt_tick_gen #(.SYS_CLK_HZ(64'd131072), .RT_HZ(64'd32768), .ACC_W(32'd32)) dut4 (
    .clk(clk), .reset(reset), .clk_ce(1'b0), .bus_write(1'b0),
    .bus_address_in(24'h000000), .bus_data_in(8'h00), .bus_data_out(rdata4), .rt_ce(rt_ce4),
    .irq_32hz(irq4[0]), .irq_8hz(irq4[1]), .irq_2hz(irq4[2]), .irq_1hz(irq4[3]));

  rt_tick_gen dut40 (
    .clk(clk), .reset(reset), .clk_ce(1'b0), .bus_write(1'b0),
    .bus_address_in(24'h000000), .bus_data_in(8'h00), .bus_data_out(rdata40), .rt_ce(rt_ce40),
    .irq_32hz(irq40[0]), .irq_8hz(irq40[1]), .irq_2hz(irq40[2]), .irq_1hz(irq40[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state (fast instance)
  longint unsigned k;
  logic m_en;
  logic m_rt;
  int   m_sub;
  int   m_cnt;
  logic m_ev;
  int   m_ev_cnt;

  // Observation counters
  int first4, n4, n40, all4;
  int ob[4];
  longint unsigned k_irq32;

  typedef struct {
    logic        ce;
    logic        we;
    logic [23:0] waddr;
    logic [7:0]  wd;
    logic [23:0] raddr;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, exp, k);
    end
  endtask

  function automatic logic exp_ce(input longint unsigned inc, input longint unsigned n);
    if (n == 64'd0) return 1'b0;
    return ((n * inc) >> 32) != (((n - 64'd1) * inc) >> 32);
  endfunction

  function automatic logic [7:0] exp_read(input logic [23:0] a);
    if (a == 24'h2040) return {7'd0, m_en};
    if (a == 24'h2041) return 8'(m_cnt);
    return 8'h00;
  endfunction

  task automatic model_reset();
    k = 64'd0; m_en = 1'b0; m_rt = 1'b0; m_sub = 0; m_cnt = 0; m_ev = 1'b0; m_ev_cnt = 0;
    first4 = 0; n4 = 0; n40 = 0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) ob[i] = 0;
    all4 = 0;
  endtask

  // One clock: advance the model on the applied inputs, then compare all outputs.
  task automatic step();
    logic wr, en_eff;
    logic [3:0] e;
    wr = clk_ce && bus_write && (addr == 24'h2040);
    en_eff = wr ? wdata[0] : m_en;
    e = 4'b0000;
    if (m_ev) e = {m_ev_cnt == 0, (m_ev_cnt % 128) == 0, (m_ev_cnt % 32) == 0, (m_ev_cnt % 8) == 0};
    m_ev = 1'b0;
    if (wr && wdata[1]) begin
      m_sub = 0;
      m_cnt = 0;
    end else if (m_rt && en_eff) begin
      m_sub++;
      if (m_sub == 128) begin
        m_sub = 0;
        m_cnt = (m_cnt + 1) % 256;
        m_ev = 1'b1;
        m_ev_cnt = m_cnt;
      end
    end
    if (wr) m_en = wdata[0];
    @(posedge clk);
    k++;
    m_rt = exp_ce(INC_F, k);
    #1;
    check("rt_ce", 32'(rt_ce), 32'(m_rt));
    check("rt_ce_4", 32'(rt_ce4), 32'(exp_ce(INC_4, k)));
    check("rt_ce_40", 32'(rt_ce40), 32'(exp_ce(INC_40, k)));
    check("irq", 32'(irq), 32'(e));
    check("read", 32'(rdata), 32'(exp_read(addr)));
    if (rt_ce4 && first4 == 0) first4 = int'(k);
    n4 += 32'(rt_ce4);
    n40 += 32'(rt_ce40);
    for (int i = 0; i < 4; i++) ob[i] += 32'(irq[i]);
    if (irq == 4'hF) all4++;
    if (irq[0]) k_irq32 = k;
  endtask

  task automatic idle(input logic [23:0] a);
    clk_ce = 1'b0; bus_write = 1'b0; addr = a; wdata = 8'h00;
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    clk_ce = 1'b1; bus_write = 1'b1; addr = 24'h2040; wdata = d;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic to;
    longint unsigned e_cnt8;
    longint unsigned lo;
    int ce_seen;

    tbl[0]  = '{1'b1, 1'b1, 24'h2040, 8'h01, 24'h2040, 8'h01};
    tbl[1]  = '{1'b0, 1'b1, 24'h2040, 8'h00, 24'h2040, 8'h01};  // no clk_ce: ignored
    tbl[2]  = '{1'b1, 1'b0, 24'h2040, 8'h00, 24'h2040, 8'h01};
    tbl[3]  = '{1'b1, 1'b1, 24'h2042, 8'h00, 24'h2040, 8'h01};
    tbl[4]  = '{1'b1, 1'b1, 24'h203F, 8'h00, 24'h2040, 8'h01};
    tbl[5]  = '{1'b1, 1'b1, 24'h2040, 8'h00, 24'h2040, 8'h00};
    tbl[6]  = '{1'b1, 1'b1, 24'h2040, 8'hFE, 24'h2040, 8'h00};
    tbl[7]  = '{1'b1, 1'b1, 24'h2040, 8'h03, 24'h2040, 8'h01};
    tbl[8]  = '{1'b1, 1'b0, 24'h0000, 8'h00, 24'h2042, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 24'h0000, 8'h00, 24'h203F, 8'h00};
    tbl[10] = '{1'b1, 1'b0, 24'h0000, 8'h00, 24'h2041, 8'h00};
    tbl[11] = '{1'b1, 1'b1, 24'h2040, 8'h00, 24'h2041, 8'h00};

    reset = 1'b1;
    idle(24'h2040);
    model_reset();
    clear_obs();
    k_irq32 = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rt_ce", 32'({rt_ce, rt_ce4, rt_ce40}), 32'd0);
    check("reset_irq", 32'({irq, irq4, irq40}), 32'd0);
    check("reset_rd_2040", 32'(rdata), 32'h00);
    addr = 24'h2041; #1;
    check("reset_rd_2041", 32'(rdata), 32'h00);
    addr = 24'h2042; #1;
    check("reset_rd_2042", 32'(rdata), 32'h00);
    reset = 1'b0;

    // Register table
    for (int i = 0; i < 12; i++) begin
      clk_ce = tbl[i].ce; bus_write = tbl[i].we; addr = tbl[i].waddr; wdata = tbl[i].wd;
      step();
      idle(tbl[i].raddr);
      #1;
      check("tbl_read", 32'(rdata), 32'(tbl[i].exp));
      step();
    end
    check("nco4_first", 32'(first4), 32'd4);
    check("nco4_count", 32'(n4), 32'(k / 64'd4));

    // Count to 8 from a clean start
    wr_ctrl(8'h03);
    idle(24'h2041);
    clear_obs();
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (m_cnt == 8) begin to = 1'b0; break; end
    end
    check("cnt8_timeout", 32'(to), 32'd0);
    check("cnt8_read", 32'(rdata), 32'h08);
    e_cnt8 = k;
    repeat (3) step();
    check("cnt8_irq32", 32'(ob[0]), 32'd1);
    check("cnt8_irq_other", 32'(ob[1] + ob[2] + ob[3]), 32'd0);
    check("cnt8_irq_lat", 32'(k_irq32), 32'(e_cnt8 + 64'd1));

    // Wrap through 0x80 and 0xFF->0x00
    clear_obs();
    to = 1'b1;
    for (int i = 0; i < 40000; i++) begin
      step();
      if (m_cnt == 0) begin to = 1'b0; break; end
    end
    repeat (2) step();
    check("wrap_timeout", 32'(to), 32'd0);
    check("wrap_read", 32'(rdata), 32'h00);
    check("wrap_all4", 32'(all4), 32'd1);
    check("wrap_irq1", 32'(ob[3]), 32'd1);
    check("wrap_irq2", 32'(ob[2]), 32'd2);
    check("wrap_irq8", 32'(ob[1]), 32'd8);
    check("wrap_irq32", 32'(ob[0]), 32'd31);

    // Clear colliding with the tick that would make cnt 8
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (m_cnt == 7 && m_sub == 127 && m_rt && m_en) begin to = 1'b0; break; end
    end
    check("clr_timeout", 32'(to), 32'd0);
    clear_obs();
    wr_ctrl(8'h03);
    idle(24'h2041);
    #1;
    check("clr_cnt", 32'(rdata), 32'h00);
    repeat (3) step();
    check("clr_no_irq", 32'(ob[0] + ob[1] + ob[2] + ob[3]), 32'd0);
    addr = 24'h2040; #1;
    check("clr_ctrl_read", 32'(rdata), 32'h01);

    // Disable: count freezes while rt_ce keeps running
    idle(24'h2041);
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (m_cnt == 3) begin to = 1'b0; break; end
    end
    check("dis_pre_timeout", 32'(to), 32'd0);
    wr_ctrl(8'h00);
    idle(24'h2041);
    ce_seen = 0;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      ce_seen += 32'(rt_ce);
      if (ce_seen == 1000) begin to = 1'b0; break; end
    end
    check("dis_ce_timeout", 32'(to), 32'd0);
    check("dis_cnt_frozen", 32'(rdata), 32'h03);
    clk_ce = 1'b0; bus_write = 1'b1; addr = 24'h2040; wdata = 8'h03;
    step();
    idle(24'h2040); #1;
    check("noce_ctrl", 32'(rdata), 32'h00);
    addr = 24'h2041; #1;
    check("noce_cnt", 32'(rdata), 32'h03);

    // Run to 0x55, then reset asynchronously between edges
    wr_ctrl(8'h01);
    idle(24'h2041);
    to = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      step();
      if (m_cnt == 8'h55) begin to = 1'b0; break; end
    end
    check("run55_timeout", 32'(to), 32'd0);
    check("run55_read", 32'(rdata), 32'h55);
    lo = (k * 64'd32768) / 64'd40000000;
    check("nco40_total", 32'(n40), 32'((k * INC_40) >> 32));
    check("nco40_range", 32'((longint'(n40) >= lo) && (longint'(n40) <= lo + 64'd1)), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("async_rt_ce", 32'({rt_ce, rt_ce4, rt_ce40}), 32'd0);
    check("async_irq", 32'(irq), 32'd0);
    check("async_cnt", 32'(rdata), 32'h00);
    addr = 24'h2040; #1;
    check("async_ctrl", 32'(rdata), 32'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (8) step();
    check("rst_nco4_first", 32'(first4), 32'd4);

    // Randomised bus traffic against the model
    for (int i = 0; i < 6000; i++) begin
      case ($urandom_range(0, 4))
        0: addr = 24'h2040;
        1: addr = 24'h2041;
        2: addr = 24'h2042;
        3: addr = 24'h203F;
        default: addr = 24'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) addr = 24'h2040;
      bus_write = ($urandom_range(0, 9) == 0);
      clk_ce = 1'($urandom_range(0, 1));
      wdata = 8'($urandom);
      if ($urandom_range(0, 15) != 0) wdata[1] = 1'b0;
      wdata[0] = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rt_tick_gen.md
# rt_tick_gen

Real-time tick generator for the system clock domain. It sits directly upstream of the RTC and supplies the 32.768 kHz clock enable that the RTC prescaler and the rest of the real-time logic count. It derives that enable from the system clock with a fractional phase accumulator. It also implements the 256 Hz timer registers (0x2040/0x2041) and their periodic interrupt request pulses.

## Interface
Parameters:
- `SYS_CLK_HZ`, default 40_000_000: frequency of `clk` in Hz.
- `RT_HZ`, default 32768: target real-time enable rate in Hz.
- `ACC_W`, default 32: phase accumulator width in bits.

Ports:
- `clk` in 1: system clock, the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `clk_ce` in 1: CPU bus cycle enable; qualifies register writes only.
- `bus_write` in 1: write strobe.
- `bus_address_in` in 24: bus address.
- `bus_data_in` in 8: write data.
- `bus_data_out` out 8: read data, combinational.
- `rt_ce` out 1: single-`clk` pulse at the `RT_HZ` average rate; feeds the RTC real-time enable.
- `irq_32hz`, `irq_8hz`, `irq_2hz`, `irq_1hz` out 1 each: single-`clk` interrupt request pulses.

## Operation
- **NCO.**
  - `INC = round(RT_HZ * 2^ACC_W / SYS_CLK_HZ)`, computed at elaboration. Elaboration error if `INC == 0` or `INC >= 2^ACC_W`.
  - Every `clk` the accumulator does `acc <= acc + INC`, modulo 2^ACC_W.
  - `rt_ce` = registered carry-out of that add. Free-running; not gated by `clk_ce` or the timer enable.
- **Prescaler.**
  - 7-bit `pre` increments on `rt_ce` when `enabled`.
  - `pre` wraps 127→0 and generates `tick256` on the cycle it wraps.
- **Counter.**
  - 8-bit `cnt` increments on `tick256`; wraps 0xFF→0x00.
- **Register writes.** Accepted on the rising `clk` edge where `clk_ce && bus_write`.
  - 0x2040: bit0 → `enabled`.
  - 0x2040: bit1 = 1 → one-shot clear of `pre` and `cnt`. Self-clearing; not stored.
  - Writes to any other address are ignored.
- **Reads.**
  - 0x2040 → `{7'd0, enabled}`.
  - 0x2041 → `cnt`.
  - Any other address → 0x00.
- **IRQ pulses.** Asserted for the cycle after the `cnt` update that produces the listed value:
  - `irq_32hz` when `cnt[2:0]` becomes 0.
  - `irq_8hz` when `cnt[4:0]` becomes 0.
  - `irq_2hz` when `cnt[6:0]` becomes 0.
  - `irq_1hz` when `cnt` becomes 0x00 by wrap.
  - Several pulses may coincide.
- **Boundary conditions.**
  - Clear write and `tick256` in the same cycle: clear wins. `cnt` = 0, no IRQ pulse.
  - Enable=0 write and `rt_ce` in the same cycle: `pre` does not advance.
  - A clear never produces an IRQ, even though `cnt` becomes 0.
  - With `enabled` = 0, `pre` and `cnt` hold; `rt_ce` continues.

## Timing
- Reset values: `acc` = 0, `rt_ce` = 0, `enabled` = 0, `pre` = 0, `cnt` = 0, all `irq_*` = 0. `bus_data_out` = 0x00 for every address except 0x2040 and 0x2041, both of which also read 0x00 after reset.
- First `rt_ce` occurs `ceil(2^ACC_W / INC)` cycles after reset release. Long-term period error is at most 1 `clk`, with no drift beyond the rounding of `INC`.
- `rt_ce` → `pre` update: 1 cycle.
- `pre` wrap → `cnt` update: same edge (`tick256` is combinational from `pre == 127 && rt_ce && enabled`).
- `cnt` update → `irq_*`: 1 cycle (registered).
- Register write → visible on read: next cycle.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Pulses in flight are dropped.

## Structure
- Package `rt_pkg`:
  - Address constants `RT_TIMER256_CTRL` = 24'h2040 and `RT_TIMER256_CNT` = 24'h2041.
  - Control bit positions `EN_BIT` = 0 and `CLR_BIT` = 1.
  - Function computing `INC` from the parameters.
- Sub-module `rt_nco`: the parameterised phase accumulator producing `rt_ce`. It is reused by any future block needing a fractional-rate enable.
- Top level holds the register file, `pre`, `cnt` and IRQ generation.

## Test plan
- **NCO rate.** `SYS_CLK_HZ` = 131072, `ACC_W` = 32, so `INC` = 2^30. Release reset → first `rt_ce` on cycle 4, then exactly every 4 cycles. Also `SYS_CLK_HZ` = 40e6 over 10^6 cycles → 819 or 820 pulses.
- **Timer count.** Write 0x01 to 0x2040, run 128×8 `rt_ce` → 0x2041 reads 0x08. `irq_32hz` pulses once, 1 cycle after `cnt` becomes 0x08; no other IRQ fires.
- **Wrap.** Enable and run 256 `tick256` → `cnt` = 0x00. `irq_1hz`, `irq_2hz`, `irq_8hz` and `irq_32hz` all pulse on the same cycle. `irq_2hz` also pulsed earlier at `cnt` = 0x80.
- **Clear collision.** Write 0x03 to 0x2040 in the cycle where `tick256` fires with `cnt` = 0x07 → `cnt` = 0x00, `pre` = 0, no `irq_32hz`. Read of 0x2040 returns 0x01.
- **Disable and qualification.** Write 0x00 to 0x2040 → `cnt` and `pre` frozen for 1000 `rt_ce`, `rt_ce` still toggling. A write with `clk_ce` = 0 has no effect. Reads of 0x2042 and 0x203F return 0x00.
- **Async reset mid-run.** Assert `reset` between edges with `cnt` = 0x55 → outputs zero before the next edge. After release, the first `rt_ce` occurs at the same cycle offset as at power-up.
